map_write_queue: RTL

//  Write-side companion to the tile-map renderer. Buffers block-type updates for the
//  13x13 play-field map from game logic, and commits them to the map storage write port

---
 rtl/map_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/map_write_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared types for the play-field map write path: coordinate/block widths,
// the queued write-request record and the write-queue state encoding.
package map_pkg;

  localparam int MAP_DIM      = 13;
  localparam int MAP_COORD_W  = 4;
  localparam int BLOCK_TYPE_W = 3;

  typedef logic [BLOCK_TYPE_W-1:0] block_type_t;
  typedef logic [MAP_COORD_W-1:0]  map_coord_t;

  // "type" is a keyword, so the block field is named blk_type.
  typedef struct packed {
    map_coord_t  x;
    map_coord_t  y;
    block_type_t blk_type;
  } map_wr_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_DRAIN
  } wq_state_t;

  function automatic logic coord_in_range(input map_coord_t x, input map_coord_t y);
    return (x < map_coord_t'(MAP_DIM)) && (y < map_coord_t'(MAP_DIM));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and
// pop is ignored when empty. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign rdata_o = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/map_write_queue.sv
// Buffers map block updates and commits them to the map write port only during
// vertical blanking. Define MAP_WRITE_BOUNDS_CHECK_EN to drop and flag off-map requests.
module map_write_queue
  import map_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int VBLANK_START = 480,
  parameter int VBLANK_END   = 524
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [3:0]             req_x_i,
  input  logic [3:0]             req_y_i,
  input  logic [2:0]             req_type_i,
  input  logic [9:0]             vpos_i,
  output logic                   map_we_o,
  output logic [3:0]             map_x_o,
  output logic [3:0]             map_y_o,
  output logic [2:0]             map_type_o,
  output logic [$clog2(DEPTH):0] pending_o,
  output logic                   drain_done_o,
  output logic                   err_o
);

  localparam int         CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [9:0] VB_START = 10'(VBLANK_START);
  localparam logic [9:0] VB_END   = 10'(VBLANK_END);

  wq_state_t        state_q;
  wq_state_t        state_d;
  map_wr_req_t      req;
  map_wr_req_t      head;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             vblank;
  logic             handshake;
  logic             push;
  logic             pop;
  logic             we_q;
  map_wr_req_t      wr_q;
  logic             done_q;

  assign vblank      = (vpos_i >= VB_START) && (vpos_i <= VB_END);
  assign req         = '{x: req_x_i, y: req_y_i, blk_type: req_type_i};
  assign req_ready_o = !full;
  assign handshake   = req_valid_i && req_ready_o;

`ifdef MAP_WRITE_BOUNDS_CHECK_EN
  logic in_range;
  logic err_q;

  assign in_range = coord_in_range(req_x_i, req_y_i);
  assign push     = handshake && in_range;
  assign err_o    = err_q;

  // Off-map requests complete the handshake but are discarded and flagged.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= handshake && !in_range;
  end
`else
  assign push  = handshake;
  assign err_o = 1'b0;
`endif

  sync_fifo #(
    .WIDTH ($bits(map_wr_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (req),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign pending_o  = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_PENDING;
    if (count_next == '0) state_d = ST_IDLE;
    else if (vblank)      state_d = ST_DRAIN;
  end

  // state_q tracks occupancy exactly; live vblank stops popping the cycle blanking ends.
  always_comb begin
    pop = 1'b0;
    if (state_q != ST_IDLE && vblank && !empty) pop = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      wr_q   <= '0;
      done_q <= 1'b0;
    end else begin
      we_q   <= pop;
      done_q <= pop && !push && (count == CNT_W'(1));
      if (pop) wr_q <= head;
    end
  end

  assign map_we_o     = we_q;
  assign map_x_o      = wr_q.x;
  assign map_y_o      = wr_q.y;
  assign map_type_o   = wr_q.blk_type;
  assign drain_done_o = done_q;

endmodule
